crc4_arb: RTL and testbench

CRC4_ARB -- requirements
Module: crc4_arb

---
 rtl/crc4_arb.sv | 125 ++++++++++++
 tb/tb_crc4_arb.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/crc4_arb.sv
// Two-requester round-robin front end for a CRC-4 engine.
// One word is in flight at a time; the response is held until the consumer accepts it.
module crc4_arb #(
    parameter int TIMEOUT = 63,
    parameter int DW      = 26
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    output logic          eng_start,
    output logic [DW-1:0] eng_data,
    input  logic          eng_done,
    input  logic [3:0]    eng_crc,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic          resp_id,
    output logic [3:0]    resp_crc,
    output logic          resp_err
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        BUSY,
        RESP
    } state_t;

    state_t          state_reg, state_next;
    logic            rr_reg, rr_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [DW-1:0]   data_reg, data_next;
    logic            id_reg, id_next;
    logic [3:0]      crc_reg, crc_next;
    logic            err_reg, err_next;

    logic            gnt0;
    logic            gnt1;

    // rr picks the winner only when both requesters contend.
    assign gnt0 = req0_valid && (!req1_valid || !rr_reg);
    assign gnt1 = req1_valid && (!req0_valid ||  rr_reg);

    // Ready is gated by rst so nothing is acknowledged while reset is held.
    assign req0_ready = (state_reg == IDLE) && !rst && gnt0;
    assign req1_ready = (state_reg == IDLE) && !rst && gnt1;

    assign eng_start  = (state_reg == START);
    assign eng_data   = data_reg;
    assign resp_valid = (state_reg == RESP);
    assign resp_id    = id_reg;
    assign resp_crc   = crc_reg;
    assign resp_err   = err_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            rr_reg    <= 1'b0;
            cnt_reg   <= '0;
            data_reg  <= '0;
            id_reg    <= 1'b0;
            crc_reg   <= 4'h0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            rr_reg    <= rr_next;
            cnt_reg   <= cnt_next;
            data_reg  <= data_next;
            id_reg    <= id_next;
            crc_reg   <= crc_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        rr_next    = rr_reg;
        cnt_next   = cnt_reg;
        data_next  = data_reg;
        id_next    = id_reg;
        crc_next   = crc_reg;
        err_next   = err_reg;
        unique case (state_reg)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    data_next  = gnt1 ? req1_data : req0_data;
                    id_next    = gnt1;
                    rr_next    = !gnt1;
                    state_next = START;
                end
            end
            START: begin
                cnt_next   = '0;
                state_next = BUSY;
            end
            BUSY: begin
                // A done in the same cycle as the timeout takes priority.
                if (eng_done) begin
                    crc_next   = eng_crc;
                    err_next   = 1'b0;
                    state_next = RESP;
                end else if (cnt_reg == CW'(TIMEOUT)) begin
                    crc_next   = 4'h0;
                    err_next   = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_crc4_arb.sv
// Directed bench for crc4_arb: arbitration, latency, timeout, backpressure and reset cases.
module tb_crc4_arb;

    localparam int DW = 26;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0;
    logic [DW-1:0] req0_data = '0;
    logic          req0_ready;
    logic          req1_valid = 1'b0;
    logic [DW-1:0] req1_data = '0;
    logic          req1_ready;
    logic          eng_start;
    logic [DW-1:0] eng_data;
    logic          eng_done = 1'b0;
    logic [3:0]    eng_crc = 4'h0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic          resp_id;
    logic [3:0]    resp_crc;
    logic          resp_err;

    int asserts_cnt = 0;
    int fail_cnt = 0;
    int start_pulses = 0;

    crc4_arb #(.TIMEOUT(63), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .eng_start  (eng_start),
        .eng_data   (eng_data),
        .eng_done   (eng_done),
        .eng_crc    (eng_crc),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_crc   (resp_crc),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (eng_start === 1'b1) start_pulses++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic ack_resp();
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (2) step();
        asserts_cnt++; if (req0_ready !== 1'b0) begin fail_cnt++; $display("FAIL reset_req0_ready got=%b exp=0", req0_ready); end
        asserts_cnt++; if (req1_ready !== 1'b0) begin fail_cnt++; $display("FAIL reset_req1_ready got=%b exp=0", req1_ready); end
        asserts_cnt++; if (eng_start !== 1'b0) begin fail_cnt++; $display("FAIL reset_eng_start got=%b exp=0", eng_start); end
        asserts_cnt++; if (resp_valid !== 1'b0) begin fail_cnt++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        asserts_cnt++; if (eng_data !== '0) begin fail_cnt++; $display("FAIL reset_eng_data got=%0d exp=0", eng_data); end
        asserts_cnt++; if ({resp_id, resp_crc, resp_err} !== 6'b0) begin fail_cnt++; $display("FAIL reset_resp got=%b exp=0", {resp_id, resp_crc, resp_err}); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        $display("txn reset: outputs checked");
    endtask

    task automatic test_single();
        int s0;
        rst = 1'b0;
        req0_data = 26'd987654; req0_valid = 1'b1;
        #1;
        asserts_cnt++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin fail_cnt++; $display("FAIL single_grant got=%b%b exp=10", req0_ready, req1_ready); end
        s0 = start_pulses;
        step();
        asserts_cnt++; if (eng_start !== 1'b1 || eng_data !== 26'd987654) begin fail_cnt++; $display("FAIL single_start got=%b/%0d exp=1/987654", eng_start, eng_data); end
        asserts_cnt++; if (req0_ready !== 1'b0) begin fail_cnt++; $display("FAIL single_ready_1cyc got=%b exp=0", req0_ready); end
        req0_valid = 1'b0;
        step();
        asserts_cnt++; if (eng_start !== 1'b0 || eng_data !== 26'd987654) begin fail_cnt++; $display("FAIL single_busy got=%b/%0d exp=0/987654", eng_start, eng_data); end
        repeat (25) step();
        asserts_cnt++; if (resp_valid !== 1'b0) begin fail_cnt++; $display("FAIL single_early_resp got=%b exp=0", resp_valid); end
        eng_done = 1'b1; eng_crc = 4'hA;
        step();
        eng_done = 1'b0;
        asserts_cnt++; if ({resp_valid, resp_id, resp_crc, resp_err} !== {1'b1, 1'b0, 4'hA, 1'b0}) begin fail_cnt++; $display("FAIL single_resp got=%b/%b/%h/%b exp=1/0/a/0", resp_valid, resp_id, resp_crc, resp_err); end
        asserts_cnt++; if (start_pulses - s0 !== 1) begin fail_cnt++; $display("FAIL single_pulses got=%0d exp=1", start_pulses - s0); end
        ack_resp();
        asserts_cnt++; if (resp_valid !== 1'b0) begin fail_cnt++; $display("FAIL single_ack got=%b exp=0", resp_valid); end
        $display("txn single: id=%b crc=%h", 1'b0, 4'hA);
    endtask

    task automatic test_contention();
        logic          exp_id;
        logic [DW-1:0] exp_data;
        rst = 1'b1;
        req0_data = 26'd987654; req1_data = 26'd6666666;
        req0_valid = 1'b1; req1_valid = 1'b1;
        step();
        rst = 1'b0;
        for (int r = 0; r < 3; r++) begin
            exp_id = (r == 1);
            exp_data = exp_id ? 26'd6666666 : 26'd987654;
            #1;
            asserts_cnt++; if ({req0_ready, req1_ready} !== {!exp_id, exp_id}) begin fail_cnt++; $display("FAIL contend_grant r=%0d got=%b%b exp=%b%b", r, req0_ready, req1_ready, !exp_id, exp_id); end
            step();
            asserts_cnt++; if (eng_start !== 1'b1 || eng_data !== exp_data) begin fail_cnt++; $display("FAIL contend_start r=%0d got=%b/%0d exp=1/%0d", r, eng_start, eng_data, exp_data); end
            eng_done = 1'b1; eng_crc = 4'hF;
            step();
            asserts_cnt++; if (resp_valid !== 1'b0) begin fail_cnt++; $display("FAIL contend_done_in_start r=%0d got=%b exp=0", r, resp_valid); end
            eng_crc = 4'(r + 1);
            step();
            eng_done = 1'b0;
            asserts_cnt++; if (resp_valid !== 1'b1 || resp_id !== exp_id || resp_crc !== 4'(r + 1)) begin fail_cnt++; $display("FAIL contend_resp r=%0d got=%b/%b/%h exp=1/%b/%h", r, resp_valid, resp_id, resp_crc, exp_id, 4'(r + 1)); end
            resp_ready = 1'b1;
            #1;
            asserts_cnt++; if ({req0_ready, req1_ready} !== 2'b00) begin fail_cnt++; $display("FAIL contend_same_cycle r=%0d got=%b%b exp=00", r, req0_ready, req1_ready); end
            step();
            resp_ready = 1'b0;
            $display("txn contention round %0d: id=%b data=%0d", r, exp_id, exp_data);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_timeout();
        apply_reset();
        req0_data = 26'd123; req0_valid = 1'b1;
        #1;
        step();
        req0_valid = 1'b0;
        step();
        repeat (63) step();
        asserts_cnt++; if (resp_valid !== 1'b0) begin fail_cnt++; $display("FAIL timeout_early got=%b exp=0", resp_valid); end
        step();
        asserts_cnt++; if ({resp_valid, resp_err, resp_crc} !== {1'b1, 1'b1, 4'h0}) begin fail_cnt++; $display("FAIL timeout_resp got=%b/%b/%h exp=1/1/0", resp_valid, resp_err, resp_crc); end
        ack_resp();
        $display("txn timeout: err=%b crc=%h", resp_err, resp_crc);
        req1_data = 26'd6666666; req1_valid = 1'b1;
        #1;
        asserts_cnt++; if (req1_ready !== 1'b1) begin fail_cnt++; $display("FAIL timeout_next_grant got=%b exp=1", req1_ready); end
        step();
        req1_valid = 1'b0;
        step();
        eng_done = 1'b1; eng_crc = 4'h5;
        step();
        eng_done = 1'b0;
        asserts_cnt++; if ({resp_valid, resp_id, resp_err, resp_crc} !== {1'b1, 1'b1, 1'b0, 4'h5}) begin fail_cnt++; $display("FAIL timeout_next_resp got=%b/%b/%b/%h exp=1/1/0/5", resp_valid, resp_id, resp_err, resp_crc); end
        ack_resp();
        $display("txn after timeout: id=1 crc=5");
    endtask

    task automatic test_backpressure();
        int s0;
        apply_reset();
        req0_data = 26'd987654; req1_data = 26'd6666666;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        step();
        step();
        eng_done = 1'b1; eng_crc = 4'hC;
        step();
        eng_done = 1'b0;
        s0 = start_pulses;
        for (int i = 0; i < 10; i++) begin
            asserts_cnt++;
            if ({resp_valid, resp_id, resp_crc, resp_err, req0_ready, req1_ready, eng_start} !== {1'b1, 1'b0, 4'hC, 1'b0, 3'b000}) begin
                fail_cnt++;
                $display("FAIL stall_cycle%0d got=%b/%b/%h/%b rdy=%b%b st=%b exp=1/0/c/0 rdy=00 st=0", i, resp_valid, resp_id, resp_crc, resp_err, req0_ready, req1_ready, eng_start);
            end
            step();
        end
        asserts_cnt++; if (start_pulses !== s0) begin fail_cnt++; $display("FAIL stall_pulses got=%0d exp=%0d", start_pulses, s0); end
        ack_resp();
        asserts_cnt++; if ({req0_ready, req1_ready} !== 2'b01) begin fail_cnt++; $display("FAIL stall_rr_grant got=%b%b exp=01", req0_ready, req1_ready); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        $display("txn backpressure: id=0 crc=c held 10 cycles");
    endtask

    task automatic test_reset_busy();
        apply_reset();
        req0_data = 26'd987654; req0_valid = 1'b1;
        #1;
        step();
        req0_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        eng_done = 1'b1; eng_crc = 4'h9;
        #1;
        asserts_cnt++; if ({eng_start, resp_valid, resp_id, resp_crc, resp_err} !== 8'b0 || eng_data !== '0) begin fail_cnt++; $display("FAIL rstbusy_async got=%b/%b/%b/%h/%b data=%0d exp=all 0", eng_start, resp_valid, resp_id, resp_crc, resp_err, eng_data); end
        step();
        rst = 1'b0;
        step();
        asserts_cnt++; if (resp_valid !== 1'b0 || eng_start !== 1'b0) begin fail_cnt++; $display("FAIL rstbusy_late_done got=%b/%b exp=0/0", resp_valid, eng_start); end
        eng_done = 1'b0;
        req1_data = 26'd6666666; req1_valid = 1'b1;
        #1;
        asserts_cnt++; if (req1_ready !== 1'b1) begin fail_cnt++; $display("FAIL rstbusy_grant got=%b exp=1", req1_ready); end
        step();
        asserts_cnt++; if (eng_start !== 1'b1 || eng_data !== 26'd6666666) begin fail_cnt++; $display("FAIL rstbusy_start got=%b/%0d exp=1/6666666", eng_start, eng_data); end
        req1_valid = 1'b0;
        step();
        eng_done = 1'b1; eng_crc = 4'h6;
        step();
        eng_done = 1'b0;
        asserts_cnt++; if ({resp_valid, resp_id, resp_crc, resp_err} !== {1'b1, 1'b1, 4'h6, 1'b0}) begin fail_cnt++; $display("FAIL rstbusy_resp got=%b/%b/%h/%b exp=1/1/6/0", resp_valid, resp_id, resp_crc, resp_err); end
        ack_resp();
        $display("txn reset in busy: follow-up id=1 crc=6");
    endtask

    task automatic test_coincidence();
        apply_reset();
        req1_data = 26'd42; req1_valid = 1'b1;
        #1;
        step();
        req1_valid = 1'b0;
        step();
        repeat (63) step();
        eng_done = 1'b1; eng_crc = 4'h7;
        step();
        eng_done = 1'b0;
        asserts_cnt++; if ({resp_valid, resp_id, resp_crc, resp_err} !== {1'b1, 1'b1, 4'h7, 1'b0}) begin fail_cnt++; $display("FAIL coincide_resp got=%b/%b/%h/%b exp=1/1/7/0", resp_valid, resp_id, resp_crc, resp_err); end
        ack_resp();
        $display("txn coincidence: id=1 crc=7 err=0");
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_timeout();
        test_backpressure();
        test_reset_busy();
        test_coincidence();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts_cnt, fail_cnt);
        $finish;
    end

endmodule
